// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor that resolves one GROUP-bit lookahead group per stage.
// Optional macro CLA_SAT_EN replaces an overflowed result with the signed saturation value.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk_1Hz,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / GROUP;

  // Ranks 0..NSTG-1 carry operands, the inter-group carry and the finished low sum bits.
  // Rank NSTG is the result register, so only its valid bit lives in vld_q.
  logic [NSTG:0]    vld_q, vld_d;
  logic [WIDTH-1:0] a_q     [NSTG];
  logic [WIDTH-1:0] a_d     [NSTG];
  logic [WIDTH-1:0] b_q     [NSTG];
  logic [WIDTH-1:0] b_d     [NSTG];
  logic [WIDTH-1:0] sum_q   [NSTG];
  logic [WIDTH-1:0] sum_d   [NSTG];
  logic             carry_q [NSTG];
  logic             carry_d [NSTG];
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             adv;
  logic [GROUP:0]   grp;
  logic [WIDTH-1:0] full;

  // Flattened lookahead: every carry is a sum of generate terms propagated upward plus the group carry-in.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] ga,
                                               input logic [GROUP-1:0] gb,
                                               input logic             c0);
    logic [GROUP-1:0] p, g;
    logic [GROUP:0]   c;
    logic             term;
    p    = ga ^ gb;
    g    = ga & gb;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

`ifdef CLA_SAT_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic a_msb);
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  always_comb begin
    adv      = ~vld_q[NSTG] | out_ready;
    in_ready = adv;
    vld_d    = vld_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    s_d      = s_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    grp      = '0;
    full     = '0;
    if (adv) begin
      // Stage 0: accept and precondition the operands for subtraction.
      vld_d[0]   = in_valid;
      a_d[0]     = a;
      b_d[0]     = sub ? ~b : b;
      carry_d[0] = sub ? ~cin : cin;
      sum_d[0]   = '0;
      // Stages 1..NSTG-1: resolve group k-1 and forward the remaining operand bits.
      for (int k = 1; k < NSTG; k++) begin
        grp        = cla_group(a_q[k-1][(k-1)*GROUP +: GROUP],
                               b_q[k-1][(k-1)*GROUP +: GROUP], carry_q[k-1]);
        vld_d[k]   = vld_q[k-1];
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        carry_d[k] = grp[GROUP];
        sum_d[k]   = sum_q[k-1];
        sum_d[k][(k-1)*GROUP +: GROUP] = grp[GROUP-1:0];
      end
      // Final stage: top group, flags and optional saturation; result only loads on a valid slot.
      vld_d[NSTG] = vld_q[NSTG-1];
      if (vld_q[NSTG-1]) begin
        grp  = cla_group(a_q[NSTG-1][(NSTG-1)*GROUP +: GROUP],
                         b_q[NSTG-1][(NSTG-1)*GROUP +: GROUP], carry_q[NSTG-1]);
        full = sum_q[NSTG-1];
        full[(NSTG-1)*GROUP +: GROUP] = grp[GROUP-1:0];
        cout_d = grp[GROUP];
        ovf_d  = (a_q[NSTG-1][WIDTH-1] == b_q[NSTG-1][WIDTH-1]) &
                 (full[WIDTH-1] != a_q[NSTG-1][WIDTH-1]);
        s_d    = full;
`ifdef CLA_SAT_EN
        if (ovf_d) s_d = sat_value(a_q[NSTG-1][WIDTH-1]);
`endif
      end
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      vld_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_1Hz) begin
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
  end

  assign out_valid = vld_q[NSTG];
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases plus a randomized stream checked against an arithmetic model.
// Honours CLA_SAT_EN when the design is built with saturation.
module tb_cla_pipe_adder;
  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int NSTG  = WIDTH / GROUP;

  logic             clk_1Hz = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  always #5 clk_1Hz = ~clk_1Hz;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
    int               acc_stalls;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   n_out = 0;
  bit   head_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t lit(input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es; e.cout = ec; e.ovf = eo; e.acc_cyc = 0; e.acc_stalls = 0;
    return e;
  endfunction

  // Plain integer arithmetic: the unsigned result gives s/cout, the signed one gives overflow.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc, input logic msub);
    logic [WIDTH:0] u;
    int             r;
    exp_t           e;
    if (!msub) begin
      u = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
      r = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      e.cout = u[WIDTH];
    end else begin
      u = {1'b0, ma} - {1'b0, mb} - (WIDTH+1)'(mc);
      r = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
      e.cout = ~u[WIDTH];
    end
    e.ovf = (r > 32767) || (r < -32768);
    e.s   = u[WIDTH-1:0];
`ifdef CLA_SAT_EN
    if (e.ovf) e.s = ma[WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif
    e.acc_cyc = 0; e.acc_stalls = 0;
    return e;
  endfunction

  // One clock: drive inputs, check outputs before the rising edge, record accepts.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic icin, input logic isub, input logic ior, input logic irst,
                       input exp_t e, output bit acc);
    exp_t ne;
    in_valid = iv; a = ia; b = ib; cin = icin; sub = isub; out_ready = ior; rst_n = irst;
    #1;
    acc = 0;
    if (irst) begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      check("no_spurious", out_valid && (q.size() == 0), 0);
      if (out_valid && q.size() > 0) begin
        if (!head_seen) begin
          check("latency", cyc, q[0].acc_cyc + NSTG + 1 + (stalls - q[0].acc_stalls));
          head_seen = 1;
        end
        check("s", s, q[0].s);
        check("cout", cout, q[0].cout);
        check("ovf", ovf, q[0].ovf);
        if (out_ready) begin
          void'(q.pop_front());
          head_seen = 0;
          n_out++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        ne = e; ne.acc_cyc = cyc; ne.acc_stalls = stalls;
        q.push_back(ne);
      end
      if (out_valid && !out_ready) stalls++;
    end
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
    if (!irst) begin
      q.delete();
      head_seen = 0;
    end
    cyc++;
  endtask

  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb, input logic sc,
                      input logic ss, input exp_t e, input bit rnd_ready);
    bit acc;
    acc = 0;
    for (int t = 0; t < 50 && !acc; t++)
      cycle(1'b1, sa, sb, sc, ss, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1, e, acc);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input logic ior);
    bit acc;
    for (int t = 0; t < n; t++) cycle(1'b0, '0, '0, 1'b0, 1'b0, ior, 1'b1, lit('0, 0, 0), acc);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 60 && q.size() > 0; t++)
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, lit('0, 0, 0), acc);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit               acc;
    int               base;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;

    @(negedge clk_1Hz);
    // 1: reset held three cycles, then quiet outputs
    for (int t = 0; t < 3; t++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, lit('0, 0, 0), acc);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    idle(4, 1'b1);

    // 2: simple adds
    send(16'h0002, 16'h0001, 1'b0, 1'b0, lit(16'h0003, 0, 0), 0);
    send(16'h0006, 16'h0002, 1'b1, 1'b0, lit(16'h0009, 0, 0), 0);
    drain();

    // 3: carry wrap and signed overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, lit(16'h0000, 1, 0), 0);
`ifdef CLA_SAT_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, lit(16'h7FFF, 0, 1), 0);
`else
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, lit(16'h8000, 0, 1), 0);
`endif
    drain();

    // 4: subtraction, borrow and overflow
    send(16'h0005, 16'h0007, 1'b0, 1'b1, lit(16'hFFFE, 0, 0), 0);
    send(16'h000A, 16'h000D, 1'b0, 1'b1, lit(16'hFFFD, 0, 0), 0);
`ifdef CLA_SAT_EN
    send(16'h8000, 16'h0001, 1'b0, 1'b1, lit(16'h8000, 1, 1), 0);
`else
    send(16'h8000, 16'h0001, 1'b0, 1'b1, lit(16'h7FFF, 1, 1), 0);
`endif
    drain();

    // 5: eight back-to-back sets under random backpressure
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1);
    end
    drain();
    check("stream8_count", n_out - base, 8);

    // randomized traffic with random valid and ready
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)), ra, rb, rc, rs, 1'($urandom_range(0, 1)), 1'b1,
            model(ra, rb, rc, rs), acc);
    end
    drain();

    // 6: fill with out_ready low, reset during the stall, then a fresh add
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      cycle(1'b1, ra, rb, 1'b0, 1'b0, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b0), acc);
    end
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, lit('0, 0, 0), acc);
    rst_n = 1'b1;
    #1;
    check("stall_rst_out_valid", out_valid, 0);
    check("stall_rst_in_ready", in_ready, 1);
    idle(2, 1'b1);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, lit(16'h0007, 0, 0), 0);
    drain();
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
